// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the configuration-chain memory: load-protocol
// state encoding and the counter-width helper.
package cfg_chain_pkg;

    // Load-protocol states of the configuration chain.
    typedef enum logic [1:0] {
        CFG_IDLE  = 2'b00,
        CFG_SHIFT = 2'b01,
        CFG_ARMED = 2'b10,
        CFG_OVER  = 2'b11
    } cfg_state_e;

    // Ceiling log2; used to size the shift counter so it can hold WIDTH.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cfg_shift_chain.sv
// Serial shadow chain: bit 0 takes the serial input, every other bit takes
// its lower neighbour. The tail is the last flop of the chain itself, so the
// head-to-tail latency is exactly WIDTH accepted shifts.
module cfg_shift_chain #(
    parameter int               WIDTH     = 6,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             prog_clk,
    input  logic             prog_reset_n,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic             dout
);

    logic [WIDTH-1:0] sr_r;

    generate
        if (WIDTH == 1) begin : g_single
            // Single-bit chain: the only flop loads the serial input on a shift.
            always_ff @(posedge prog_clk or negedge prog_reset_n) begin
                if (!prog_reset_n) begin
                    sr_r <= RESET_VAL;
                end else if (shift_en) begin
                    sr_r[0] <= din;
                end else begin
                    sr_r <= sr_r;
                end
            end
        end else begin : g_multi
            // Multi-bit chain: move every bit one position toward the tail.
            always_ff @(posedge prog_clk or negedge prog_reset_n) begin
                if (!prog_reset_n) begin
                    sr_r <= RESET_VAL;
                end else if (shift_en) begin
                    sr_r <= {sr_r[WIDTH-2:0], din};
                end else begin
                    sr_r <= sr_r;
                end
            end
        end
    endgenerate

    assign q    = sr_r;
    assign dout = sr_r[WIDTH-1];

endmodule

// File: rtl/mux_cfg_chain_mem.sv
// Configuration memory with a serial shadow chain and a separately committed
// active register. The active bits only change on an accepted commit, so the
// fabric keeps its current configuration while a new one is shifted in.
module mux_cfg_chain_mem
    import cfg_chain_pkg::*;
#(
    parameter int               WIDTH     = 6,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             prog_clk,
    input  logic             prog_reset_n,
    input  logic             ccff_head,
    input  logic             shift_en,
    input  logic             commit,
    input  logic             clear,
    output logic             ccff_tail,
    output logic [WIDTH-1:0] mem_out,
    output logic [WIDTH-1:0] mem_outb,
    output logic             chain_full,
    output logic             cfg_valid,
    output logic             err
);

    localparam int               CNT_W    = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    cfg_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] mem_out_r;
    logic             chain_full_r;
    logic             cfg_valid_r;
    logic             err_r;
    logic [WIDTH-1:0] sr_s;
    logic             tail_s;
    logic             commit_ok_s;
    logic             err_set_s;

    cfg_shift_chain #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_chain (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .shift_en     (shift_en),
        .din          (ccff_head),
        .q            (sr_s),
        .dout         (tail_s)
    );

    // A commit is only honoured with a full chain and no simultaneous shift;
    // any other commit, or shifting past a full chain, is a protocol error.
    assign commit_ok_s = commit && !shift_en && (state_r == CFG_ARMED);
    assign err_set_s   = (commit && !commit_ok_s) || (shift_en && (state_r == CFG_ARMED));

    // Load-protocol FSM, shift counter, sticky error and active register.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_r      <= CFG_IDLE;
            cnt_r        <= CNT_ZERO;
            mem_out_r    <= RESET_VAL;
            chain_full_r <= 1'b0;
            cfg_valid_r  <= 1'b0;
            err_r        <= 1'b0;
        end else if (clear) begin
            // Abort the load; the active configuration is deliberately kept.
            state_r      <= CFG_IDLE;
            cnt_r        <= CNT_ZERO;
            chain_full_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            case (state_r)
                CFG_IDLE: begin
                    if (shift_en) begin
                        cnt_r <= CNT_ONE;
                        if (WIDTH == 1) begin
                            state_r      <= CFG_ARMED;
                            chain_full_r <= 1'b1;
                        end else begin
                            state_r      <= CFG_SHIFT;
                            chain_full_r <= 1'b0;
                        end
                    end else begin
                        state_r      <= CFG_IDLE;
                        chain_full_r <= 1'b0;
                    end
                end
                CFG_SHIFT: begin
                    if (shift_en) begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == (FULL_CNT - CNT_ONE)) begin
                            state_r      <= CFG_ARMED;
                            chain_full_r <= 1'b1;
                        end else begin
                            state_r      <= CFG_SHIFT;
                            chain_full_r <= 1'b0;
                        end
                    end else begin
                        state_r      <= CFG_SHIFT;
                        chain_full_r <= 1'b0;
                    end
                end
                CFG_ARMED: begin
                    if (shift_en) begin
                        // Counter saturates at WIDTH; OVER itself records the excess.
                        state_r      <= CFG_OVER;
                        chain_full_r <= 1'b0;
                    end else if (commit_ok_s) begin
                        state_r      <= CFG_IDLE;
                        cnt_r        <= CNT_ZERO;
                        chain_full_r <= 1'b0;
                        mem_out_r    <= sr_s;
                        cfg_valid_r  <= 1'b1;
                    end else begin
                        state_r      <= CFG_ARMED;
                        chain_full_r <= 1'b1;
                    end
                end
                CFG_OVER: begin
                    state_r      <= CFG_OVER;
                    chain_full_r <= 1'b0;
                end
                default: begin
                    state_r      <= CFG_IDLE;
                    cnt_r        <= CNT_ZERO;
                    chain_full_r <= 1'b0;
                end
            endcase
        end
    end

    assign ccff_tail  = tail_s;
    assign mem_out    = mem_out_r;
    assign mem_outb   = ~mem_out_r;
    assign chain_full = chain_full_r;
    assign cfg_valid  = cfg_valid_r;
    assign err        = err_r;

endmodule

// File: tb/tb_mux_cfg_chain_mem.sv
// Bench for mux_cfg_chain_mem: a WIDTH=6 and a WIDTH=1 instance share one
// input stream and are compared against a behavioural model built from a
// history of shifted bits and a count of shifts since the last idle entry.
module tb_mux_cfg_chain_mem;

    logic prog_clk = 1'b0;
    logic prog_reset_n = 1'b0;
    logic ccff_head = 1'b0;
    logic shift_en = 1'b0;
    logic commit = 1'b0;
    logic clear = 1'b0;

    logic       tail6, full6, valid6, err6;
    logic [5:0] mem6, memb6;
    logic       tail1, full1, valid1, err1;
    logic [0:0] mem1, memb1;

    int errors = 0;
    int checks = 0;

    // model state: hist[i] is the i-th most recent shadow bit (hist[0] newest)
    bit         hist[$];
    int         n[2];
    bit         m_err[2];
    bit         m_valid[2];
    logic [5:0] m_mem[2];
    int         wd[2] = '{6, 1};

    mux_cfg_chain_mem #(.WIDTH(6), .RESET_VAL(6'b000000)) dut6 (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .ccff_head(ccff_head),
        .shift_en(shift_en), .commit(commit), .clear(clear), .ccff_tail(tail6),
        .mem_out(mem6), .mem_outb(memb6), .chain_full(full6), .cfg_valid(valid6), .err(err6)
    );

    mux_cfg_chain_mem #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .ccff_head(ccff_head),
        .shift_en(shift_en), .commit(commit), .clear(clear), .ccff_tail(tail1),
        .mem_out(mem1), .mem_outb(memb1), .chain_full(full1), .cfg_valid(valid1), .err(err1)
    );

    always #5 prog_clk = ~prog_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 6; i++) hist.push_back(1'b0);
        for (int k = 0; k < 2; k++) begin
            n[k] = 0; m_err[k] = 1'b0; m_valid[k] = 1'b0; m_mem[k] = 6'b000000;
        end
    endtask

    task automatic model_step(input bit sh, input bit hd, input bit cm, input bit cl);
        logic [5:0] snap;
        snap = 6'b000000;
        for (int i = 0; i < 6; i++) snap[i] = hist[i];
        for (int k = 0; k < 2; k++) begin
            if (cl) begin
                n[k] = 0;
                m_err[k] = 1'b0;
            end else begin
                if (cm) begin
                    if (n[k] == wd[k] && !sh) begin
                        m_mem[k] = (k == 0) ? snap : {5'b00000, snap[0]};
                        m_valid[k] = 1'b1;
                        n[k] = 0;
                    end else begin
                        m_err[k] = 1'b1;
                    end
                end
                if (sh) begin
                    if (n[k] == wd[k]) m_err[k] = 1'b1;
                    n[k] = n[k] + 1;
                end
            end
        end
        if (sh) begin
            hist.push_front(hd);
            void'(hist.pop_back());
        end
    endtask

    function automatic logic [15:0] exp6();
        return {hist[5], (n[0] == 6), m_valid[0], m_err[0], m_mem[0], ~m_mem[0]};
    endfunction

    function automatic logic [15:0] obs6();
        return {tail6, full6, valid6, err6, mem6, memb6};
    endfunction

    function automatic logic [5:0] exp1();
        return {hist[0], (n[1] == 1), m_valid[1], m_err[1], m_mem[1][0], ~m_mem[1][0]};
    endfunction

    function automatic logic [5:0] obs1();
        return {tail1, full1, valid1, err1, mem1, memb1};
    endfunction

    task automatic cycle(input bit sh, input bit hd, input bit cm, input bit cl);
        shift_en = sh; ccff_head = hd; commit = cm; clear = cl;
        @(posedge prog_clk);
        model_step(sh, hd, cm, cl);
        #1;
        shift_en = 1'b0; ccff_head = 1'b0; commit = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        prog_reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        #1;
        checks++;
        if (obs6() !== 16'h003F) begin
            errors++; $display("FAIL reset_w6: got %h expected %h", obs6(), 16'h003F);
        end
        checks++;
        if (obs1() !== 6'b000001) begin
            errors++; $display("FAIL reset_w1: got %b expected %b", obs1(), 6'b000001);
        end
    endtask

    task automatic test_load_commit();
        logic [5:0] pat;
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, pat[5-i], 1'b0, 1'b0);
            checks++;
            if (obs6() !== exp6()) begin
                errors++; $display("FAIL load_shift%0d: got %h expected %h", i, obs6(), exp6());
            end
        end
        checks++;
        if ({full6, tail6} !== 2'b11) begin
            errors++; $display("FAIL load_full: got full=%b tail=%b expected full=1 tail=1", full6, tail6);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({mem6, memb6, valid6, err6, full6} !== {6'b101101, 6'b010010, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_commit: got mem=%b memb=%b valid=%b err=%b full=%b expected 101101 010010 1 0 0",
                               mem6, memb6, valid6, err6, full6);
        end
        checks++;
        if (obs1() !== exp1()) begin
            errors++; $display("FAIL load_commit_w1: got %b expected %b", obs1(), exp1());
        end
    endtask

    task automatic test_partial_shift();
        logic [2:0] tseq;
        tseq = 3'b110;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({mem6, full6, tail6} !== {6'b101101, 1'b0, tseq[i]}) begin
                errors++; $display("FAIL partial%0d: got mem=%b full=%b tail=%b expected mem=101101 full=0 tail=%b",
                                   i, mem6, full6, tail6, tseq[i]);
            end
        end
    endtask

    task automatic test_overflow();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
            checks++;
            if (obs6() !== exp6()) begin
                errors++; $display("FAIL over_fill%0d: got %h expected %h", i, obs6(), exp6());
            end
        end
        cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
        checks++;
        if ({full6, err6} !== 2'b01) begin
            errors++; $display("FAIL over_7th: got full=%b err=%b expected full=0 err=1", full6, err6);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({mem6, valid6, err6} !== {6'b101101, 1'b1, 1'b1}) begin
            errors++; $display("FAIL over_commit: got mem=%b valid=%b err=%b expected 101101 1 1", mem6, valid6, err6);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({full6, err6, mem6} !== {1'b0, 1'b0, 6'b101101}) begin
            errors++; $display("FAIL over_clear: got full=%b err=%b mem=%b expected 0 0 101101", full6, err6, mem6);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
            checks++;
            if (obs6() !== exp6()) begin
                errors++; $display("FAIL over_refill%0d: got %h expected %h", i, obs6(), exp6());
            end
        end
    endtask

    task automatic test_commit_with_shift();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 1'($urandom), 1'b1, 1'b0);
        checks++;
        if ({err6, full6, mem6} !== {1'b1, 1'b0, 6'b101101}) begin
            errors++; $display("FAIL commit_shift: got err=%b full=%b mem=%b expected 1 0 101101", err6, full6, mem6);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs6() !== exp6()) begin
            errors++; $display("FAIL commit_in_over: got %h expected %h", obs6(), exp6());
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
        #2;
        prog_reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs6() !== 16'h003F) begin
            errors++; $display("FAIL async_reset_w6: got %h expected %h", obs6(), 16'h003F);
        end
        checks++;
        if (obs1() !== 6'b000001) begin
            errors++; $display("FAIL async_reset_w1: got %b expected %b", obs1(), 6'b000001);
        end
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        #1;
    endtask

    task automatic test_width1();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs1() !== 6'b110001) begin
            errors++; $display("FAIL w1_shift: got %b expected %b", obs1(), 6'b110001);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs1() !== 6'b101010) begin
            errors++; $display("FAIL w1_commit: got %b expected %b", obs1(), 6'b101010);
        end
        checks++;
        if (obs6() !== exp6()) begin
            errors++; $display("FAIL w1_commit_w6: got %h expected %h", obs6(), exp6());
        end
    endtask

    task automatic test_random();
        bit sh, hd, cm, cl;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            sh = ($urandom_range(0, 99) < 60);
            cm = ($urandom_range(0, 99) < 15);
            cl = ($urandom_range(0, 99) < 4);
            hd = 1'($urandom);
            if ((n[0] == 6 || n[0] > 8) && $urandom_range(0, 1) == 1) begin
                sh = (n[0] > 8) ? 1'b0 : 1'b0;
                cm = (n[0] == 6);
                cl = (n[0] > 8);
            end
            cycle(sh, hd, cm, cl);
            checks++;
            if (obs6() !== exp6()) begin
                errors++; $display("FAIL random_w6 cyc%0d: got %h expected %h", i, obs6(), exp6());
            end
            checks++;
            if (obs1() !== exp1()) begin
                errors++; $display("FAIL random_w1 cyc%0d: got %b expected %b", i, obs1(), exp1());
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_commit();
        test_partial_shift();
        test_overflow();
        test_commit_with_shift();
        test_async_reset();
        test_width1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_cfg_chain_mem.md
MUX_CFG_CHAIN_MEM -- requirements
Module: mux_cfg_chain_mem

Interface
REQ-001 Parameter WIDTH, default 6, number of configuration bits held (legal range 1..64).
REQ-002 Parameter RESET_VAL, default all-zero WIDTH-bit vector, value loaded into the shadow chain and active outputs on reset.
REQ-003 prog_clk  input  1  configuration clock; all state changes occur on its rising edge.
REQ-004 prog_reset_n  input  1  asynchronous, active-low reset.
REQ-005 ccff_head  input  1  serial configuration data in.
REQ-006 shift_en  input  1  advance shadow chain by one bit this cycle.
REQ-007 commit  input  1  single-cycle request to transfer shadow chain to active outputs.
REQ-008 clear  input  1  synchronous abort: drop the in-progress load and clear errors.
REQ-009 ccff_tail  output  1  serial data out, equal to the last shadow bit.
REQ-010 mem_out  output  WIDTH  active configuration bits.
REQ-011 mem_outb  output  WIDTH  bitwise complement of mem_out at all times.
REQ-012 chain_full  output  1  exactly WIDTH bits shifted since the last IDLE entry.
REQ-013 cfg_valid  output  1  mem_out holds a committed configuration.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 Shadow chain sr[0..WIDTH-1]: on shift_en, sr[0] takes ccff_head and sr[i] takes sr[i-1]; otherwise it holds.
REQ-016 ccff_tail shall equal sr[WIDTH-1] driven from a flop, giving WIDTH cycles of head-to-tail shift latency.
REQ-017 mem_out shall change only on an accepted commit, so the active configuration stays stable while a new one is shifted in.
REQ-018 A bit counter of width clog2(WIDTH+1) shall count accepted shifts, reset to 0 on IDLE entry and never wrap.
REQ-019 States: IDLE (cnt=0), SHIFT (0<cnt<WIDTH), ARMED (cnt=WIDTH), OVER (more than WIDTH shifts).
REQ-020 Transitions: IDLE→SHIFT on shift_en, or IDLE→ARMED when WIDTH=1; SHIFT→ARMED on the shift that reaches WIDTH; ARMED→OVER on shift_en; ARMED→IDLE on accepted commit.
REQ-021 An accepted commit is commit=1 with shift_en=0 in ARMED: mem_out<=sr at that edge (visible next cycle), cfg_valid<=1, state→IDLE.
REQ-022 commit in IDLE, SHIFT or OVER, or commit together with shift_en in any state, shall set err, leave mem_out unchanged and still perform any requested shift.
REQ-023 Entering OVER shall set err; OVER persists with shifts still propagating to ccff_tail until clear or reset.
REQ-024 clear=1 shall force state IDLE, cnt 0 and err 0, leave sr, mem_out and cfg_valid unchanged, and take priority over commit and the counter update; the sr shift still occurs if shift_en=1.
REQ-025 chain_full shall be 1 exactly in ARMED.
REQ-026 err shall be cleared only by clear or reset.

Reset
REQ-027 On prog_reset_n low, asynchronously: sr=RESET_VAL, mem_out=RESET_VAL, mem_outb=~RESET_VAL, cnt=0, state IDLE, cfg_valid=0, err=0, chain_full=0, ccff_tail=RESET_VAL[WIDTH-1].
REQ-028 Reset asserted mid-load shall abandon the load with no partial commit; deassertion is assumed synchronised externally.

Structure
REQ-029 The state enumeration and a counter-width function clog2 shall live in shared package cfg_chain_pkg.
REQ-030 The shift chain shall be one sub-module, cfg_shift_chain (WIDTH, prog_clk, prog_reset_n, shift_en, din, q[WIDTH], dout); control FSM and active register reside in the top.

Verification (WIDTH=6, RESET_VAL=0)
REQ-031 Reset, then shift 101101 (first bit first) with 6 shift_en pulses, then commit → chain_full=1 after shift 6; mem_out[0:5]=101101 and mem_outb=010010 one cycle after commit; cfg_valid=1; err=0.
REQ-032 After REQ-031, shift 3 bits of 111 → mem_out stays 101101, chain_full=0, ccff_tail emits the shadow bits in order.
REQ-033 Shift 6 bits then a 7th → state OVER, err=1; a following commit leaves mem_out unchanged; clear → err=0, state IDLE.
REQ-034 Shift 6 bits, then commit and shift_en in the same cycle → err=1, mem_out unchanged, state OVER.
REQ-035 Assert prog_reset_n low mid-cycle after 4 shifts → all outputs return to their reset values immediately, without waiting for a clock edge.
REQ-036 WIDTH=1: one shift of 1 then commit → mem_out=1, mem_outb=0, chain_full=1 after the single shift.
